set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter NrWays, default 2, number of ways per set (1, 2 or 4).
REQ-002 SHALL have parameter NrSets, default 32, number of sets (power of two, 2..256).
REQ-003 SHALL have parameter NrWordsPerLine, default 4, 32-bit words per line (power of two, 2..16).
REQ-004 SHALL have port clk_i, in, 1, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rstn_i, in, 1, asynchronous active-low reset.
REQ-006 SHALL have port addr_i, in, 32, byte address of the read request; bits [1:0] ignored.
REQ-007 SHALL have port read_en_i, in, 1, read request.
REQ-008 SHALL have port ready_o, out, 1, request can be accepted.
REQ-009 SHALL have port flush_i, in, 1, invalidate all lines.
REQ-010 SHALL have port read_valid_o, out, 1, single-cycle pulse marking read_word_o valid.
REQ-011 SHALL have port read_word_o, out, 32, returned word.
REQ-012 SHALL have port mem_addr_o, out, 32, line-aligned refill address.
REQ-013 SHALL have port mem_read_en_o, out, 1, refill request, level, held until serviced.
REQ-014 SHALL have port mem_read_valid_i, in, 1, refill data valid.
REQ-015 SHALL have port mem_read_data_i, in, 32*NrWordsPerLine, refill line; word k at bits [32k+31:32k].

Function
REQ-016 SHALL split the address into word select addr[W+1:2], set index addr[W+S+1:W+2] and tag addr[31:W+S+2], where W=log2(NrWordsPerLine) and S=log2(NrSets).
REQ-017 SHALL implement FSM IDLE, LOOKUP, REFILL; ready_o SHALL be 1 only in IDLE.
REQ-018 IDLE: read_en_i=1 and flush_i=0 SHALL register addr_i and enter LOOKUP.
REQ-019 LOOKUP, hit (valid way with matching tag): SHALL register read_word_o from that way, pulse read_valid_o the next cycle, mark the way MRU and return to IDLE; hit latency is 2 cycles from acceptance.
REQ-020 LOOKUP, miss: SHALL enter REFILL.
REQ-021 REFILL: mem_read_en_o=1 and mem_addr_o={tag,set,(W+2)'b0} SHALL hold until mem_read_valid_i=1.
REQ-022 On that edge the block SHALL write line, tag and valid into the victim way, mark it MRU, register the requested word from mem_read_data_i, pulse read_valid_o the next cycle and return to IDLE.
REQ-023 Victim selection SHALL pick the lowest-numbered invalid way, otherwise the LRU way.
REQ-024 LRU state SHALL be kept per set as a log2(NrWays)-bit age per way.
REQ-025 On an access, ways younger than the accessed way SHALL age by 1 and the accessed way's age SHALL become 0.
REQ-026 mem_read_valid_i SHALL be ignored outside REFILL.
REQ-027 flush_i=1 in IDLE SHALL clear every valid bit in one cycle and take priority over read_en_i in the same cycle (request not accepted).
REQ-028 flush_i SHALL be ignored outside IDLE.
REQ-029 A new request SHALL be acceptable in the same cycle read_valid_o is high.
REQ-030 With NrWays=1 the block SHALL behave as a direct-mapped cache with the same timing.

Reset
REQ-031 Reset SHALL force IDLE, clear all valid bits, set way w age to w in every set, and drive ready_o=1, read_valid_o=0, read_word_o=0, mem_read_en_o=0, mem_addr_o=0.
REQ-032 Reset asserted mid-REFILL SHALL drop mem_read_en_o immediately (asynchronously) and discard the pending request.
REQ-033 Line data arrays are not reset.

Configuration
REQ-034 With macro CACHE_STATS_EN defined, the block SHALL add outputs hit_count_o and miss_count_o (32 bits each, reset 0), incremented once per LOOKUP outcome and saturating at 0xFFFF_FFFF; without the macro these ports and counters SHALL be absent and behaviour is otherwise identical.

Verification (defaults; line 16 B; set stride 0x200)
REQ-035 After reset, read 0x0000_1004 -> mem_read_en_o=1 with mem_addr_o=0x0000_1000; return line words {D3,D2,D1,D0} -> read_word_o=D1 and read_valid_o pulses once, one cycle after mem_read_valid_i.
REQ-036 Repeat read 0x0000_1004 -> read_valid_o two cycles after acceptance with D1, while mem_read_en_o stays 0.
REQ-037 Reads 0x000, 0x200, 0x000 (hit), 0x400 -> 0x400 evicts 0x200; then 0x200 misses and 0x000 misses (it is now LRU).
REQ-038 Fill 0x000, pulse flush_i with read_en_i=1 -> request not accepted; the next read of 0x000 misses.
REQ-039 Assert rstn_i=0 in REFILL -> mem_read_en_o=0 the same cycle; after release ready_o=1, a late mem_read_valid_i is ignored and no read_valid_o occurs.
REQ-040 With CACHE_STATS_EN, after REQ-037 sequence -> hit_count_o=1, miss_count_o=5.

Source files
------------

// File: rtl/set_assoc_cache.sv
// Set-associative read-only cache with LRU replacement and line refill.
// Optional hit/miss statistics counters are compiled in with CACHE_STATS_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; flush clears all valid bits here
// LOOKUP | tag compare on the registered address; hit returns the word
// REFILL | miss: line request held on the memory port until data comes
module set_assoc_cache #(
  parameter int NrWays         = 2,
  parameter int NrSets         = 32,
  parameter int NrWordsPerLine = 4
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [31:0]                 addr_i,
  input  logic                        read_en_i,
  output logic                        ready_o,
  input  logic                        flush_i,
  output logic                        read_valid_o,
  output logic [31:0]                 read_word_o,
  output logic [31:0]                 mem_addr_o,
  output logic                        mem_read_en_o,
  input  logic                        mem_read_valid_i,
  input  logic [32*NrWordsPerLine-1:0] mem_read_data_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 hit_count_o,
  output logic [31:0]                 miss_count_o
`endif
);

  localparam int W    = $clog2(NrWordsPerLine);
  localparam int S    = $clog2(NrSets);
  localparam int TagW = 30 - W - S;
  localparam int WayW = (NrWays > 1) ? $clog2(NrWays) : 1;
  localparam int AgeW = (NrWays > 1) ? $clog2(NrWays) : 1;
  localparam int LineW = 32 * NrWordsPerLine;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_e;

  state_e state_q, state_d;
  logic [29:0] req_q, req_d;
  logic [31:0] word_q, word_d;
  logic        rvalid_q, rvalid_d;

  logic             valid_q [NrSets][NrWays];
  logic [AgeW-1:0]  age_q   [NrSets][NrWays];
  logic [TagW-1:0]  tag_q   [NrSets][NrWays];
  logic [LineW-1:0] data_q  [NrSets][NrWays];

  logic [W-1:0]    lu_word;
  logic [S-1:0]    lu_set;
  logic [TagW-1:0] lu_tag;
  logic [W+4:0]    word_bit;

  logic            hit, found_inv;
  logic [WayW-1:0] hit_way, victim_way, acc_way;
  logic [AgeW-1:0] acc_age;
  logic            do_flush, do_fill, do_touch;

  // Byte offset bits are meaningless for word reads.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[1:0];

  assign lu_word  = req_q[W-1:0];
  assign lu_set   = req_q[W+S-1:W];
  assign lu_tag   = req_q[29:W+S];
  assign word_bit = {lu_word, 5'b0};

  assign ready_o       = (state_q == IDLE);
  assign read_valid_o  = rvalid_q;
  assign read_word_o   = word_q;
  // Driven straight from state so reset drops the request asynchronously.
  assign mem_read_en_o = (state_q == REFILL);
  assign mem_addr_o    = (state_q == REFILL) ? {lu_tag, lu_set, {(W+2){1'b0}}} : 32'h0;
  assign acc_age       = age_q[lu_set][acc_way];

  // Tag compare and victim choice: first invalid way, else the oldest way.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    found_inv  = 1'b0;
    victim_way = '0;
    for (int w = 0; w < NrWays; w++) begin
      if (!hit && valid_q[lu_set][w] && (tag_q[lu_set][w] == lu_tag)) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
    for (int w = 0; w < NrWays; w++) begin
      if (!found_inv && !valid_q[lu_set][w]) begin
        found_inv  = 1'b1;
        victim_way = WayW'(w);
      end
    end
    if (!found_inv) begin
      for (int w = 0; w < NrWays; w++) begin
        if (age_q[lu_set][w] == AgeW'(NrWays - 1)) victim_way = WayW'(w);
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    word_d   = word_q;
    rvalid_d = 1'b0;
    do_flush = 1'b0;
    do_fill  = 1'b0;
    do_touch = 1'b0;
    acc_way  = hit_way;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          do_flush = 1'b1;
        end else if (read_en_i) begin
          req_d   = addr_i[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          word_d   = data_q[lu_set][hit_way][word_bit +: 32];
          rvalid_d = 1'b1;
          do_touch = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        acc_way = victim_way;
        if (mem_read_valid_i) begin
          word_d   = mem_read_data_i[word_bit +: 32];
          rvalid_d = 1'b1;
          do_fill  = 1'b1;
          do_touch = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      word_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      word_q   <= word_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Valid bits and per-way LRU ages; accessed way becomes youngest.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < NrSets; s++) begin
        for (int w = 0; w < NrWays; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AgeW'(w);
        end
      end
    end else begin
      if (do_flush) begin
        for (int s = 0; s < NrSets; s++) begin
          for (int w = 0; w < NrWays; w++) valid_q[s][w] <= 1'b0;
        end
      end
      if (do_fill) valid_q[lu_set][victim_way] <= 1'b1;
      if (do_touch) begin
        for (int w = 0; w < NrWays; w++) begin
          if (WayW'(w) == acc_way) age_q[lu_set][w] <= '0;
          else if (age_q[lu_set][w] < acc_age) age_q[lu_set][w] <= age_q[lu_set][w] + 1'b1;
        end
      end
    end
  end

  // Tag and line storage, written on refill only; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_fill) begin
      tag_q[lu_set][victim_way]  <= lu_tag;
      data_q[lu_set][victim_way] <= mem_read_data_i;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

  // Saturating counters, one step per lookup outcome.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache at default parameters (2 ways, 32 sets,
// 16-byte lines). Statistics checks are included when CACHE_STATS_EN is set.
module tb_set_assoc_cache;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic [31:0]  addr_i;
  logic         read_en_i;
  logic         ready_o;
  logic         flush_i;
  logic         read_valid_o;
  logic [31:0]  read_word_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_en_o;
  logic         mem_read_valid_i;
  logic [127:0] mem_read_data_i;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count_o;
  logic [31:0]  miss_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  set_assoc_cache dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .addr_i           (addr_i),
    .read_en_i        (read_en_i),
    .ready_o          (ready_o),
    .flush_i          (flush_i),
    .read_valid_o     (read_valid_o),
    .read_word_o      (read_word_o),
    .mem_addr_o       (mem_addr_o),
    .mem_read_en_o    (mem_read_en_o),
    .mem_read_valid_i (mem_read_valid_i),
    .mem_read_data_i  (mem_read_data_i)
`ifdef CACHE_STATS_EN
    ,
    .hit_count_o      (hit_count_o),
    .miss_count_o     (miss_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Distinct, recognisable word k of the memory line at base.
  function automatic logic [31:0] line_word(input logic [31:0] base, input int k);
    return 32'hA000_0000 + (base << 4) + 32'(k);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = line_word(base, k);
    return l;
  endfunction

  task automatic apply_reset();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
  endtask

  // One read, starting #1 after a clock edge with the cache in IDLE.
  task automatic do_read(input string tag, input logic [31:0] a, input logic exp_miss);
    logic [31:0] base;
    logic [31:0] exp_word;
    base     = a & 32'hFFFF_FFF0;
    exp_word = line_word(base, int'(a[3:2]));
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
    addr_i    = a;
    read_en_i = 1'b1;
    @(posedge clk_i); #1;
    read_en_i = 1'b0;
    check({tag, "_lookup_nv"}, 32'(read_valid_o), 32'd0);
    @(posedge clk_i); #1;
    if (!exp_miss) begin
      check({tag, "_hit_memen"}, 32'(mem_read_en_o), 32'd0);
      check({tag, "_hit_valid"}, 32'(read_valid_o), 32'd1);
      check({tag, "_hit_word"}, read_word_o, exp_word);
      if (mem_read_en_o) begin
        mem_read_data_i  = line_of(base);
        mem_read_valid_i = 1'b1;
        @(posedge clk_i); #1;
        mem_read_valid_i = 1'b0;
      end
    end else begin
      check({tag, "_miss_memen"}, 32'(mem_read_en_o), 32'd1);
      check({tag, "_miss_addr"}, mem_addr_o, base);
      check({tag, "_miss_nv"}, 32'(read_valid_o), 32'd0);
      @(posedge clk_i); #1;
      check({tag, "_miss_hold"}, 32'(mem_read_en_o), 32'd1);
      mem_read_data_i  = line_of(base);
      mem_read_valid_i = 1'b1;
      @(posedge clk_i); #1;
      mem_read_valid_i = 1'b0;
      check({tag, "_fill_valid"}, 32'(read_valid_o), 32'd1);
      check({tag, "_fill_word"}, read_word_o, exp_word);
      check({tag, "_fill_memen"}, 32'(mem_read_en_o), 32'd0);
    end
  endtask

  initial begin
    rstn_i           = 1'b0;
    addr_i           = '0;
    read_en_i        = 1'b0;
    flush_i          = 1'b0;
    mem_read_valid_i = 1'b0;
    mem_read_data_i  = '0;

    #2;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(read_valid_o), 32'd0);
    check("rst_word", read_word_o, 32'h0);
    check("rst_memen", 32'(mem_read_en_o), 32'd0);
    check("rst_memaddr", mem_addr_o, 32'h0);
`ifdef CACHE_STATS_EN
    check("rst_hits", hit_count_o, 32'h0);
    check("rst_misses", miss_count_o, 32'h0);
`endif
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Refill then hits on several words of the same line, back to back.
    do_read("first_1004", 32'h0000_1004, 1'b1);
    do_read("again_1004", 32'h0000_1004, 1'b0);
    do_read("word_100c", 32'h0000_100C, 1'b0);
    do_read("word_1000", 32'h0000_1003, 1'b0);
    @(posedge clk_i); #1;
    check("pulse_end", 32'(read_valid_o), 32'd0);

    // LRU eviction sequence in set 0 from a clean cache.
    apply_reset();
    @(posedge clk_i); #1;
    do_read("lru_000", 32'h0000_0000, 1'b1);
    do_read("lru_200", 32'h0000_0200, 1'b1);
    do_read("lru_000_hit", 32'h0000_0000, 1'b0);
    do_read("lru_400", 32'h0000_0400, 1'b1);
    do_read("lru_200_evicted", 32'h0000_0200, 1'b1);
    do_read("lru_000_evicted", 32'h0000_0000, 1'b1);
    @(posedge clk_i); #1;
`ifdef CACHE_STATS_EN
    check("stat_hits", hit_count_o, 32'd1);
    check("stat_misses", miss_count_o, 32'd5);
`endif

    // Flush wins over a simultaneous request; line 0x000 is gone afterwards.
    flush_i   = 1'b1;
    read_en_i = 1'b1;
    addr_i    = 32'h0000_0000;
    @(posedge clk_i); #1;
    flush_i   = 1'b0;
    read_en_i = 1'b0;
    check("flush_not_accepted", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    check("flush_no_valid", 32'(read_valid_o), 32'd0);
    check("flush_no_memen", 32'(mem_read_en_o), 32'd0);
    do_read("post_flush_000", 32'h0000_0000, 1'b1);
    @(posedge clk_i); #1;

    // Reset in the middle of a refill.
    addr_i    = 32'h0000_0800;
    read_en_i = 1'b1;
    @(posedge clk_i); #1;
    read_en_i = 1'b0;
    @(posedge clk_i); #1;
    check("midrst_refill", 32'(mem_read_en_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    check("midrst_memen", 32'(mem_read_en_o), 32'd0);
    check("midrst_memaddr", mem_addr_o, 32'h0);
    check("midrst_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    rstn_i           = 1'b1;
    mem_read_data_i  = line_of(32'h0000_0800);
    mem_read_valid_i = 1'b1;
    @(posedge clk_i); #1;
    mem_read_valid_i = 1'b0;
    check("late_valid_ignored", 32'(read_valid_o), 32'd0);
    check("late_ready", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    check("late_no_valid", 32'(read_valid_o), 32'd0);
    check("late_no_memen", 32'(mem_read_en_o), 32'd0);
    do_read("after_rst_1004", 32'h0000_1004, 1'b1);
    @(posedge clk_i); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
